// File: rtl/lim_counter_pkg.sv
// Shared definitions for the limited counter cascade: direction encodings.
package lim_counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/lim_digit.sv
// One limited-counter digit: range 0..LIM-1, steps up or down with wrap,
// and loads a sanitised value (out-of-range load becomes 0).
module lim_digit
  import lim_counter_pkg::*;
#(
  parameter int unsigned N   = 4,
  parameter int unsigned LIM = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ld,
  input  logic [N-1:0] ld_val,
  input  logic         step,
  input  logic         up,
  output logic [N-1:0] q,
  output logic         at_max,
  output logic         at_min,
  output logic         clamp
);

  // N+1 bits so that LIM == 2**N compares without overflow.
  localparam logic [N:0]   LimW   = (N+1)'(LIM);
  localparam logic [N-1:0] MaxVal = N'(LIM - 1);

  logic [N-1:0] q_d, q_q;

  assign clamp  = {1'b0, ld_val} >= LimW;
  assign at_max = {1'b0, q_q} == (LimW - 1'b1);
  assign at_min = q_q == '0;
  assign q      = q_q;

  always_comb begin
    q_d = q_q;
    if (ld) begin
      q_d = clamp ? '0 : ld_val;
    end else if (step) begin
      if (up == DIR_UP) begin
        q_d = at_max ? '0 : q_q + 1'b1;
      end else begin
        q_d = at_min ? MaxVal : q_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

endmodule

// File: rtl/lim_counter.sv
// Cascade of DIGITS limited digits with up/down counting, parallel load,
// a registered full-wrap pulse (co) and a registered load-clamp pulse (ld_err).
module lim_counter
  import lim_counter_pkg::*;
#(
  parameter int unsigned N      = 4,
  parameter int unsigned DIGITS = 2,
  parameter int unsigned L      = 10,
  parameter int unsigned L_MS   = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic                up,
  input  logic                ld,
  input  logic [N*DIGITS-1:0] din,
  output logic [N*DIGITS-1:0] count,
  output logic                co,
  output logic                ld_err
);

  logic [DIGITS-1:0] step;
  logic [DIGITS-1:0] at_max;
  logic [DIGITS-1:0] at_min;
  logic [DIGITS-1:0] clamp;

  logic co_d, co_q;
  logic ld_err_d, ld_err_q;

  // Ripple carry/borrow: digit k steps only when every lower digit is at its edge.
  always_comb begin
    step[0] = en & ~ld;
    for (int k = 1; k < int'(DIGITS); k++) begin
      step[k] = step[k-1] & ((up == DIR_DOWN) ? at_min[k-1] : at_max[k-1]);
    end
  end

  for (genvar k = 0; k < int'(DIGITS); k++) begin : g_digit
    lim_digit #(
      .N  (N),
      .LIM((k == int'(DIGITS) - 1) ? L_MS : L)
    ) u_digit (
      .clk   (clk),
      .reset (reset),
      .ld    (ld),
      .ld_val(din[k*N +: N]),
      .step  (step[k]),
      .up    (up),
      .q     (count[k*N +: N]),
      .at_max(at_max[k]),
      .at_min(at_min[k]),
      .clamp (clamp[k])
    );
  end

  always_comb begin
    co_d     = en & ~ld & ((up == DIR_DOWN) ? (&at_min) : (&at_max));
    ld_err_d = ld & (|clamp);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      co_q     <= 1'b0;
      ld_err_q <= 1'b0;
    end else begin
      co_q     <= co_d;
      ld_err_q <= ld_err_d;
    end
  end

  assign co     = co_q;
  assign ld_err = ld_err_q;

endmodule

// File: tb/tb_lim_counter.sv
// Bench for lim_counter (N=4, DIGITS=2, L=10, L_MS=6): mixed-radix integer model
// checked every cycle, plus directed vectors with literal expectations.
module tb_lim_counter;

  localparam int N      = 4;
  localparam int DIGITS = 2;
  localparam int L      = 10;
  localparam int L_MS   = 6;
  localparam int W      = N * DIGITS;

  logic         clk = 1'b0;
  logic         reset, en, up, ld;
  logic [W-1:0] din;
  logic [W-1:0] count;
  logic         co, ld_err;

  int tests = 0;
  int fails = 0;

  lim_counter #(
    .N     (N),
    .DIGITS(DIGITS),
    .L     (L),
    .L_MS  (L_MS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .up    (up),
    .ld    (ld),
    .din   (din),
    .count (count),
    .co    (co),
    .ld_err(ld_err)
  );

  always #5 clk = ~clk;

  function automatic int lim_of(int k);
    return (k == DIGITS - 1) ? L_MS : L;
  endfunction

  function automatic int modulus();
    int m = 1;
    for (int k = 0; k < DIGITS; k++) m = m * lim_of(k);
    return m;
  endfunction

  // Integer value -> packed digit vector.
  function automatic logic [W-1:0] to_vec(int v);
    logic [W-1:0] r = '0;
    for (int k = 0; k < DIGITS; k++) begin
      r[k*N +: N] = N'(v % lim_of(k));
      v = v / lim_of(k);
    end
    return r;
  endfunction

  function automatic int load_val(logic [W-1:0] d);
    int v = 0;
    int wt = 1;
    for (int k = 0; k < DIGITS; k++) begin
      int dg = int'(d[k*N +: N]);
      if (dg < lim_of(k)) v = v + dg * wt;
      wt = wt * lim_of(k);
    end
    return v;
  endfunction

  function automatic bit load_err(logic [W-1:0] d);
    bit e = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (int'(d[k*N +: N]) >= lim_of(k)) e = 1'b1;
    end
    return e;
  endfunction

  int m_val   = 0;
  bit m_co    = 1'b0;
  bit m_err   = 1'b0;
  bit m_valid = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_val   <= 0;
      m_co    <= 1'b0;
      m_err   <= 1'b0;
      m_valid <= 1'b1;
    end else if (ld) begin
      m_val <= load_val(din);
      m_co  <= 1'b0;
      m_err <= load_err(din);
    end else if (en) begin
      if (up) begin
        m_val <= (m_val + 1) % modulus();
        m_co  <= (m_val == modulus() - 1);
      end else begin
        m_val <= (m_val == 0) ? modulus() - 1 : m_val - 1;
        m_co  <= (m_val == 0);
      end
      m_err <= 1'b0;
    end else begin
      m_co  <= 1'b0;
      m_err <= 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      check("model_count", 32'(count), 32'(to_vec(m_val)));
      check("model_co", 32'(co), 32'(m_co));
      check("model_ld_err", 32'(ld_err), 32'(m_err));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [W-1:0] v);
    ld  = 1'b1;
    en  = 1'b0;
    din = v;
    tick();
    ld  = 1'b0;
  endtask

  initial begin
    bit co_seen;
    reset = 1'b1;
    en    = 1'b1;
    up    = 1'b1;
    ld    = 1'b1;
    din   = 8'h25;
    tick();
    check("reset_count", 32'(count), 32'h00);
    check("reset_co", 32'(co), 32'h0);
    check("reset_ld_err", 32'(ld_err), 32'h0);

    // Count up through the full range.
    reset = 1'b0;
    ld    = 1'b0;
    en    = 1'b1;
    up    = 1'b1;
    co_seen = 1'b0;
    repeat (59) begin
      tick();
      if (co) co_seen = 1'b1;
    end
    check("up59_count", 32'(count), 32'h59);
    check("up59_no_co", 32'(co_seen), 32'h0);
    tick();
    check("up_wrap_count", 32'(count), 32'h00);
    check("up_wrap_co", 32'(co), 32'h1);
    en = 1'b0;
    tick();
    check("co_one_cycle", 32'(co), 32'h0);
    check("hold_count", 32'(count), 32'h00);

    // Load then carry into the tens digit.
    load(8'h09);
    check("load09", 32'(count), 32'h09);
    en = 1'b1;
    up = 1'b1;
    tick();
    check("carry_10", 32'(count), 32'h10);
    check("carry_no_co", 32'(co), 32'h0);

    // Down wrap from zero.
    load(8'h00);
    en = 1'b1;
    up = 1'b0;
    tick();
    check("down_wrap_count", 32'(count), 32'h59);
    check("down_wrap_co", 32'(co), 32'h1);
    tick();
    check("down_58", 32'(count), 32'h58);
    check("down_58_co", 32'(co), 32'h0);

    // Clamped loads.
    load(8'h3C);
    check("clamp_3c", 32'(count), 32'h30);
    check("clamp_3c_err", 32'(ld_err), 32'h1);
    tick();
    check("ld_err_one_cycle", 32'(ld_err), 32'h0);
    load(8'h7A);
    check("clamp_7a", 32'(count), 32'h00);
    check("clamp_7a_err", 32'(ld_err), 32'h1);
    load(8'h45);
    check("load_45", 32'(count), 32'h45);
    check("load_45_err", 32'(ld_err), 32'h0);

    // Load wins over en, then reset wins mid-count.
    ld  = 1'b1;
    en  = 1'b1;
    up  = 1'b1;
    din = 8'h25;
    tick();
    check("ld_over_en", 32'(count), 32'h25);
    ld = 1'b0;
    tick();
    check("step_26", 32'(count), 32'h26);
    tick();
    check("step_27", 32'(count), 32'h27);
    reset = 1'b1;
    tick();
    check("reset_mid", 32'(count), 32'h00);
    reset = 1'b0;

    // Direction changes across the borrow/carry boundary; checked by the model.
    load(8'h50);
    en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      up = ((i / 3) % 2 == 0) ? 1'b0 : 1'b1;
      en = (i % 7 != 6);
      tick();
    end
    en = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
